// File: rtl/vmem_port_arb.sv
// Burst-locking round-robin arbiter sharing one vector memory port between the load and store units.
// Optional owner-stall timeout is compiled in with `define VMEM_ARB_TIMEOUT_EN.
module vmem_port_arb #(
    parameter int ADDR_WIDTH = 31,
    parameter int TIMEOUT    = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_req,
    input  logic [ADDR_WIDTH:0] ld_addr,
    input  logic                ld_last,
    output logic                ld_gnt,
    input  logic                st_req,
    input  logic [ADDR_WIDTH:0] st_addr,
    input  logic                st_last,
    output logic                st_gnt,
    output logic                mem_valid,
    output logic [ADDR_WIDTH:0] mem_addr,
    output logic                mem_wr,
    input  logic                mem_ready,
    output logic                busy,
    output logic [4:0]          beat_cnt,
    output logic                timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_LD = 2'd1,
        OWN_ST = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_rr_ptr;
    logic [4:0]  r_beat_cnt;

    // Index 0 is the load unit, index 1 the store unit.
    logic [1:0]  w_own;
    logic [1:0]  w_req;
    logic [1:0]  w_last;
    logic [1:0]  w_gnt;
    logic        w_accept;
    logic        w_own_last;
    logic        w_pick_st;
    logic        w_timeout;

    assign w_own[0] = (r_state == OWN_LD);
    assign w_own[1] = (r_state == OWN_ST);
    assign w_req    = {st_req, ld_req};
    assign w_last   = {st_last, ld_last};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unit
            assign w_gnt[gi] = w_own[gi] & w_req[gi] & mem_ready;
        end
    endgenerate

    assign ld_gnt     = w_gnt[0];
    assign st_gnt     = w_gnt[1];
    assign mem_valid  = |(w_own & w_req);
    assign mem_wr     = w_own[1];
    assign busy       = |w_own;
    assign beat_cnt   = r_beat_cnt;
    assign w_accept   = mem_valid & mem_ready;
    assign w_own_last = |(w_own & w_last);

    always_comb begin
        mem_addr = '0;
        if (w_own[0]) begin
            mem_addr = ld_addr;
        end else if (w_own[1]) begin
            mem_addr = st_addr;
        end
    end

    // Store wins only when it is alone or the pointer favours it.
    assign w_pick_st = st_req & (~ld_req | r_rr_ptr);

`ifdef VMEM_ARB_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [IW-1:0] r_idle_cnt;
    logic [IW-1:0] w_idle_next;
    logic          r_timeout_err;

    assign w_idle_next = r_idle_cnt + 1'b1;
    assign w_timeout   = busy & ~mem_valid & (w_idle_next == IW'(TIMEOUT));
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (~busy || mem_valid || w_timeout) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= w_idle_next;
            end
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ld_req && !w_pick_st) begin
                        r_state    <= OWN_LD;
                        r_beat_cnt <= '0;
                    end else if (st_req) begin
                        r_state    <= OWN_ST;
                        r_beat_cnt <= '0;
                    end
                end
                OWN_LD, OWN_ST: begin
                    if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 5'd1;
                        if (w_own_last) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= ~w_own[1];
                        end
                    end else if (w_timeout) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= ~w_own[1];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vmem_port_arb.sv
// Directed bench for vmem_port_arb: table of per-cycle vectors plus hand-written long-burst and stall sequences.
module tb_vmem_port_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_req = 1'b0, ld_last = 1'b0, st_req = 1'b0, st_last = 1'b0, mem_ready = 1'b0;
    logic [31:0] ld_addr = '0, st_addr = '0;
    logic        ld_gnt, st_gnt, mem_valid, mem_wr, busy, timeout_err;
    logic [31:0] mem_addr;
    logic [4:0]  beat_cnt;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    vmem_port_arb #(.ADDR_WIDTH(31), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_last(ld_last), .ld_gnt(ld_gnt),
        .st_req(st_req), .st_addr(st_addr), .st_last(st_last), .st_gnt(st_gnt),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_ready(mem_ready),
        .busy(busy), .beat_cnt(beat_cnt), .timeout_err(timeout_err)
    );

    typedef struct {
        logic        rst;
        logic        lr;
        logic [31:0] la;
        logic        ll;
        logic        sr;
        logic [31:0] sa;
        logic        sl;
        logic        rdy;
        logic        ev;
        logic [31:0] ea;
        logic        ew;
        logic        elg;
        logic        esg;
        logic        eb;
        logic [4:0]  ec;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic lr, input logic [31:0] la, input logic ll,
                       input logic sr, input logic [31:0] sa, input logic sl, input logic rdy,
                       input logic ev, input logic [31:0] ea, input logic ew, input logic elg,
                       input logic esg, input logic eb, input logic [4:0] ec);
        vec_t v;
        v.rst = r; v.lr = lr; v.la = la; v.ll = ll; v.sr = sr; v.sa = sa; v.sl = sl; v.rdy = rdy;
        v.ev = ev; v.ea = ea; v.ew = ew; v.elg = elg; v.esg = esg; v.eb = eb; v.ec = ec;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic r, input logic lr, input logic [31:0] la, input logic ll,
                         input logic sr, input logic [31:0] sa, input logic sl, input logic rdy);
        @(negedge clk);
        rst = r; ld_req = lr; ld_addr = la; ld_last = ll;
        st_req = sr; st_addr = sa; st_last = sl; mem_ready = rdy;
        #1;
    endtask

    task automatic expect_outs(input string tag, input logic ev, input logic [31:0] ea, input logic ew,
                               input logic elg, input logic esg, input logic eb, input logic [4:0] ec,
                               input logic eterr);
        $display("[%0t] %s valid=%0b addr=0x%0h wr=%0b ld_gnt=%0b st_gnt=%0b busy=%0b cnt=%0d terr=%0b",
                 $time, tag, mem_valid, mem_addr, mem_wr, ld_gnt, st_gnt, busy, beat_cnt, timeout_err);
        chk({tag, ".mem_valid"}, 32'(mem_valid), 32'(ev));
        chk({tag, ".mem_addr"}, mem_addr, ea);
        chk({tag, ".mem_wr"}, 32'(mem_wr), 32'(ew));
        chk({tag, ".ld_gnt"}, 32'(ld_gnt), 32'(elg));
        chk({tag, ".st_gnt"}, 32'(st_gnt), 32'(esg));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".beat_cnt"}, 32'(beat_cnt), 32'(ec));
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(eterr));
    endtask

    initial begin
        // rst  lr  la      ll  sr  sa      sl  rdy | ev  ea      ew elg esg eb cnt
        // Store burst 4,5,6 after reset.
        add(1, 0, 0,      0, 0, 0,      0, 0,   0, 0,      0, 0, 0, 0, 0);
        add(0, 0, 0,      0, 1, 4,      0, 1,   0, 0,      0, 0, 0, 0, 0);
        add(0, 0, 0,      0, 1, 4,      0, 1,   1, 4,      1, 0, 1, 1, 0);
        add(0, 0, 0,      0, 1, 5,      0, 1,   1, 5,      1, 0, 1, 1, 1);
        add(0, 0, 0,      0, 1, 6,      1, 1,   1, 6,      1, 0, 1, 1, 2);
        add(0, 0, 0,      0, 0, 0,      0, 1,   0, 0,      0, 0, 0, 0, 3);
        // Simultaneous requests after reset: load first, then store, then load again.
        add(1, 0, 0,      0, 0, 0,      0, 0,   0, 0,      0, 0, 0, 0, 0);
        add(0, 1, 'h100,  0, 1, 'h200,  0, 1,   0, 0,      0, 0, 0, 0, 0);
        add(0, 1, 'h100,  0, 1, 'h200,  0, 1,   1, 'h100,  0, 1, 0, 1, 0);
        add(0, 1, 'h104,  1, 1, 'h200,  0, 1,   1, 'h104,  0, 1, 0, 1, 1);
        add(0, 0, 0,      0, 1, 'h200,  0, 1,   0, 0,      0, 0, 0, 0, 2);
        add(0, 1, 'h108,  0, 1, 'h200,  0, 1,   1, 'h200,  1, 0, 1, 1, 0);
        add(0, 1, 'h108,  0, 1, 'h204,  1, 1,   1, 'h204,  1, 0, 1, 1, 1);
        add(0, 1, 'h108,  0, 0, 0,      0, 1,   0, 0,      0, 0, 0, 0, 2);
        add(0, 1, 'h108,  1, 0, 0,      0, 1,   1, 'h108,  0, 1, 0, 1, 0);
        add(0, 0, 0,      0, 0, 0,      0, 1,   0, 0,      0, 0, 0, 0, 1);
        // Store request arriving mid load burst waits for the bubble.
        add(0, 1, 'h300,  0, 0, 0,      0, 1,   0, 0,      0, 0, 0, 0, 1);
        add(0, 1, 'h300,  0, 0, 0,      0, 1,   1, 'h300,  0, 1, 0, 1, 0);
        add(0, 1, 'h304,  0, 1, 'h400,  1, 1,   1, 'h304,  0, 1, 0, 1, 1);
        add(0, 1, 'h308,  1, 1, 'h400,  1, 1,   1, 'h308,  0, 1, 0, 1, 2);
        add(0, 0, 0,      0, 1, 'h400,  1, 1,   0, 0,      0, 0, 0, 0, 3);
        add(0, 0, 0,      0, 1, 'h400,  1, 1,   1, 'h400,  1, 0, 1, 1, 0);
        add(0, 0, 0,      0, 0, 0,      0, 1,   0, 0,      0, 0, 0, 0, 1);
        // mem_ready 1,0,0,1 on a 2-beat load.
        add(0, 1, 'h500,  0, 0, 0,      0, 1,   0, 0,      0, 0, 0, 0, 1);
        add(0, 1, 'h500,  0, 0, 0,      0, 1,   1, 'h500,  0, 1, 0, 1, 0);
        add(0, 1, 'h504,  1, 0, 0,      0, 0,   1, 'h504,  0, 0, 0, 1, 1);
        add(0, 1, 'h504,  1, 0, 0,      0, 0,   1, 'h504,  0, 0, 0, 1, 1);
        add(0, 1, 'h504,  1, 0, 0,      0, 1,   1, 'h504,  0, 1, 0, 1, 1);
        add(0, 0, 0,      0, 0, 0,      0, 1,   0, 0,      0, 0, 0, 0, 2);
        // Reset during beat 2 of a store; afterwards load wins the conflict.
        add(1, 0, 0,      0, 0, 0,      0, 0,   0, 0,      0, 0, 0, 0, 0);
        add(0, 0, 0,      0, 1, 'h600,  0, 1,   0, 0,      0, 0, 0, 0, 0);
        add(0, 0, 0,      0, 1, 'h600,  0, 1,   1, 'h600,  1, 0, 1, 1, 0);
        add(1, 0, 0,      0, 1, 'h604,  0, 1,   0, 0,      0, 0, 0, 0, 0);
        add(0, 1, 'h700,  1, 1, 'h604,  0, 1,   0, 0,      0, 0, 0, 0, 0);
        add(0, 1, 'h700,  1, 1, 'h604,  0, 1,   1, 'h700,  0, 1, 0, 1, 0);
        add(0, 0, 0,      0, 1, 'h604,  0, 1,   0, 0,      0, 0, 0, 0, 1);
        add(0, 0, 0,      0, 1, 'h604,  1, 1,   1, 'h604,  1, 0, 1, 1, 0);
        add(0, 0, 0,      0, 0, 0,      0, 1,   0, 0,      0, 0, 0, 0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].lr, vq[i].la, vq[i].ll, vq[i].sr, vq[i].sa, vq[i].sl, vq[i].rdy);
            expect_outs($sformatf("vec%0d", i), vq[i].ev, vq[i].ea, vq[i].ew, vq[i].elg,
                        vq[i].esg, vq[i].eb, vq[i].ec, 1'b0);
        end

        // 33-beat load: beat_cnt wraps modulo 32.
        drive(0, 1, 'h900, 0, 0, 0, 0, 1);
        expect_outs("long.idle", 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 33; k++) begin
            drive(0, 1, 32'h900 + 32'(k), (k == 32), 0, 0, 0, 1);
            expect_outs($sformatf("long.beat%0d", k), 1, 32'h900 + 32'(k), 0, 1, 0, 1, 5'(k % 32), 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        expect_outs("long.done", 0, 0, 0, 0, 0, 0, 1, 0);

        // Owner stalls after one beat while the store unit waits.
        drive(0, 1, 'h800, 0, 0, 0, 0, 1);
        expect_outs("stall.idle", 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 1, 'h800, 0, 0, 0, 0, 1);
        expect_outs("stall.beat", 1, 'h800, 0, 1, 0, 1, 0, 0);
`ifdef VMEM_ARB_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            drive(0, 0, 'h804, 0, 1, 'hA00, 1, 1);
            expect_outs($sformatf("stall.wait%0d", k), 0, 'h804, 0, 0, 0, 1, 1, 0);
        end
        drive(0, 0, 'h804, 0, 1, 'hA00, 1, 1);
        expect_outs("stall.release", 0, 0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 'h804, 0, 1, 'hA00, 1, 1);
        expect_outs("stall.store", 1, 'hA00, 1, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        expect_outs("stall.after", 0, 0, 0, 0, 0, 0, 1, 0);
`else
        for (int k = 1; k <= 40; k++) begin
            drive(0, 0, 'h804, 0, 1, 'hA00, 1, 1);
            expect_outs($sformatf("stall.wait%0d", k), 0, 'h804, 0, 0, 0, 1, 1, 0);
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        expect_outs("stall.reset", 0, 0, 0, 0, 0, 0, 0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vmem_port_arb.md
# vmem_port_arb

Burst-locking round-robin arbiter that shares the single vector memory port between the vector load unit and the vector store unit. Each unit raises a level request, generates its own per-beat addresses, and marks its final beat. The arbiter grants one unit at a time and holds the grant for the whole burst. It muxes the owner's beat onto the memory port and returns per-beat acceptance. It sits between the two vector memory units and the memory interface, above the vector register file address path.

## Interface
- ADDR_WIDTH, 31, MSB index of the address buses; buses are ADDR_WIDTH+1 bits wide.
- TIMEOUT, 15, idle-owner cycles before forced release; used only with the timeout feature.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ld_req  in  1  load unit has a beat or a burst pending (level).
- ld_addr  in  ADDR_WIDTH+1  load-unit beat address.
- ld_last  in  1  current load beat is the final beat of its burst.
- ld_gnt  out  1  load beat accepted this cycle.
- st_req, st_addr, st_last, st_gnt  same as the ld_* ports, for the store unit.
- mem_valid  out  1  beat presented on the memory port.
- mem_addr  out  ADDR_WIDTH+1  beat address.
- mem_wr  out  1  1 = store beat, 0 = load beat.
- mem_ready  in  1  memory accepts the beat.
- busy  out  1  a burst owner exists.
- beat_cnt  out  5  beats accepted in the current or most recent burst.
- timeout_err  out  1  one-cycle pulse on forced release.

## Operation
- States: IDLE, OWN_LD, OWN_ST. A 1-bit rr_ptr (0 = load preferred) selects the winner on conflict.
- IDLE:
  - Only ld_req set -> OWN_LD.
  - Only st_req set -> OWN_ST.
  - Both set -> owner is the unit indicated by rr_ptr.
  - Neither set -> stay in IDLE.
  - The grant decision is registered; no beat is presented while in IDLE.
- OWN_x, memory-side outputs:
  - mem_valid = x_req.
  - mem_addr = x_addr.
  - mem_wr = 1 for OWN_ST, 0 for OWN_LD.
- OWN_x, handshake:
  - x_gnt = x_req & mem_ready (combinational).
  - The other unit's gnt stays 0.
  - The port is never given away mid-burst.
- Accepted beat (mem_valid & mem_ready):
  - beat_cnt increments, modulo 32.
  - If x_last is also set: next state is IDLE and rr_ptr points at the other unit.
- On entry to OWN_x, beat_cnt clears to 0.
- In IDLE, beat_cnt holds its value so software can read the length of the last burst.
- busy = 1 in OWN_LD and OWN_ST.
- If the owner drops x_req without x_last, the arbiter keeps ownership and holds mem_valid low. Outside the timeout feature this stall has no bound.
- A request raised by the other unit while a burst is in progress waits until the current burst completes.

## Timing
- Reset values: state IDLE, rr_ptr 0, beat_cnt 0, timeout_err 0, idle counter 0. Because the state is IDLE, mem_valid, mem_wr, mem_addr, ld_gnt, st_gnt and busy all read 0 during and after reset.
- Reset asserted mid-burst: the arbiter returns to IDLE immediately and the in-flight beat is dropped.
- Request to first beat: a request seen in IDLE at edge N produces mem_valid from cycle N+1.
- Single-beat burst: occupies 1 cycle of ownership plus 1 IDLE bubble.
- N-beat burst with mem_ready held high: N cycles of ownership; back-to-back bursts are separated by exactly 1 IDLE cycle.
- Simultaneous x_last acceptance and the other unit's request: the handover appears at the memory port 2 cycles after the last beat edge (IDLE bubble, then new owner).
- mem_ready low: x_gnt = 0, the owner holds its address, and beat_cnt does not change.

## Configuration
- VMEM_ARB_TIMEOUT_EN defined:
  - An idle counter increments each OWN cycle in which x_req = 0.
  - It clears on any cycle with x_req = 1 and on entry to an OWN state.
  - When it reaches TIMEOUT, the next state is IDLE, rr_ptr flips away from the owner, and timeout_err pulses for 1 cycle.
- VMEM_ARB_TIMEOUT_EN undefined:
  - The idle counter is absent and timeout_err is tied to 0.
  - Ownership is released only by an accepted last beat or by reset.

## Test plan
- Reset, then st_req = 1 with addresses 4, 5, 6 and last on 6, mem_ready = 1 -> mem_valid on cycles 1-3, mem_wr = 1, st_gnt ×3, beat_cnt = 3, then IDLE.
- ld_req and st_req raised in the same cycle after reset, 2-beat bursts each -> load served first; store first beat appears 2 cycles after load last; the next conflict goes to load again only after the store burst completes.
- Load burst in progress; st_req asserts mid-burst -> st_gnt stays 0 until 1 cycle after the load last beat plus the IDLE bubble, and mem_addr never shows st_addr during the load burst.
- Toggle mem_ready 1, 0, 0, 1 on a 2-beat load -> ld_gnt only on the ready cycles, mem_addr stable while stalled, beat_cnt = 2 at the end.
- With VMEM_ARB_TIMEOUT_EN and TIMEOUT = 15: owner drops req after 1 beat without last -> timeout_err pulses after 15 idle cycles, busy falls, and the other pending unit wins next. Without the macro -> busy stays 1 indefinitely.
- Assert rst during beat 2 of a 4-beat store -> all outputs read 0 immediately; after release, a fresh load request is granted with rr_ptr = 0.
